alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage directly downstream of ALU control: accepts an operation code (aluop)
//  plus operands from decode and produces a registered result and zero flag for
//  memory/writeback and branch resolution.
//  Add/sub/pass complete in one cycle; sll/srl use a serial shifter (1 bit/cycle).
//  Valid/ready handshake on both sides, plus a flush input for branch redirect.
// PARAMETERS
//  XLEN     32  operand/result width
//  SHAMT_W  5   shift-amount width (log2 XLEN)
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  reset      in   1        synchronous, active-high
//  flush      in   1        drop in-flight op (sync, lower priority than reset)
//  in_valid   in   1        decode presents an op
//  in_ready   out  1        stage can accept an op this cycle
//  in_aluop   in   4        0=NONE 2=ADD 3=SLL 4=SRL 6=SUB; other codes act as NONE
//  in_a       in   XLEN     rs operand
//  in_b       in   XLEN     rt operand / sign-extended immediate
//  in_shamt   in   SHAMT_W  shift amount, used only for SLL/SRL
//  out_valid  out  1        result register holds a valid result
//  out_ready  in   1        consumer accepts result
//  out_result out  XLEN     ALU result
//  out_zero   out  1        (out_result == 0), registered with out_result
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid=0, out_result=0, out_zero=0; in_ready=1 in cycle after reset.
//  - States: IDLE (no op, no result), SHIFT (serial shift running), DONE (result held).
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//  - Accept of ADD/SUB/NONE, or SLL/SRL with shamt==0: next cycle DONE, out_valid=1.
//    ADD: a+b, SUB: a-b (mod 2^XLEN, no overflow trap); NONE: result 0;
//    SLL/SRL shamt 0: result = b.
//  - Accept of SLL/SRL with shamt=k>0: load work=b, count=k, enter SHIFT.
//    Each SHIFT cycle shifts work by 1 (logical, zero fill), decrements count;
//    when count reaches 0 the register becomes DONE.
//    Latency accept->out_valid = k+1 cycles.
//  - DONE: out_result/out_zero stable while out_valid & !out_ready.
//    out_ready & !accept -> IDLE (out_valid=0);
//    out_ready & accept -> back-to-back, no bubble.
//  - in_ready=0 during SHIFT; inputs ignored.
//  - flush (reset not asserted): state->IDLE, out_valid=0 next cycle, counter cleared;
//    an accept in the same cycle is discarded (in_ready still reports per rule above).
//  - reset overrides flush and any in-flight op; reset mid-SHIFT -> IDLE, no result emitted.
//  - out_zero computed from the final result only, never from intermediate shift values.
// STRUCTURE
//  - Shared package mips_pkg: aluop_t (logic [3:0]) and constants ALU_NONE=0, ALU_ADD=2,
//    ALU_SLL=3, ALU_SRL=4, ALU_SUB=6; also used by alucontrol; stage state enum ex_state_t.
//  - One sub-module: serial_shifter (load, dir, shamt, busy, done, result);
//    FSM and adder/subtractor stay in alu_exec_stage.
// TESTING
//  - ADD a=5 b=7, out_ready=1 -> out_valid next cycle, result=12, zero=0.
//  - ADD a=0xFFFFFFFF b=1 -> result=0, zero=1 (wrap).
//  - SUB a=9 b=9 -> result=0, zero=1.
//  - SUB a=3 b=5 -> result=0xFFFFFFFE.
//  - SLL b=1 shamt=4 -> out_valid 5 cycles after accept, result=16; in_ready=0 meanwhile.
//  - SRL b=0x80000000 shamt=31 -> result=1 after 32 cycles.
//  - SLL shamt=0, b=0xABCD -> 1-cycle, result=0xABCD.
//  - Backpressure: out_ready=0 for 3 cycles -> result/zero held, in_ready=0.
//    Then out_ready=1 with new ADD in_valid -> accepted same cycle, next result next cycle.
//  - flush at SHIFT cycle 2 of SLL shamt=10 -> IDLE, no out_valid.
//  - reset mid-SHIFT -> out_valid=0, in_ready=1 the following cycle.
//  - Unknown aluop 4'hF with a=b=7 -> result=0, zero=1, 1-cycle latency.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mips_pkg                                                         |
// | Purpose : Shared ALU opcode type and constants (used by alucontrol and the |
// |           execute stage) plus the execute-stage state encoding.           |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mips_pkg;

  // 4-bit ALU operation code produced by alucontrol.
  typedef logic [3:0] aluop_t;

  localparam aluop_t ALU_NONE = 4'd0;
  localparam aluop_t ALU_ADD  = 4'd2;
  localparam aluop_t ALU_SLL  = 4'd3;
  localparam aluop_t ALU_SRL  = 4'd4;
  localparam aluop_t ALU_SUB  = 4'd6;

  // Execute-stage control states.
  typedef enum logic [1:0] {
    EX_IDLE  = 2'd0,  // no op in flight, no result held
    EX_SHIFT = 2'd1,  // serial shifter running
    EX_DONE  = 2'd2   // result register valid
  } ex_state_t;

  // True for the two opcodes that go through the serial shifter.
  function automatic logic is_shift_op(input aluop_t op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_exec_stage_serial_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_shifter                                                   |
// | Purpose : Logical shifter that moves one bit position per clock.          |
// | Ports   : clk, reset   - clock, synchronous active-high reset              |
// |           clear        - abandon any shift in progress                     |
// |           load         - capture data_in/shamt/dir and start shifting      |
// |           dir          - 0 = shift left, 1 = shift right (zero fill)       |
// |           shamt        - number of positions (must be non-zero on load)    |
// |           data_in      - value to shift                                    |
// |           busy         - a shift is in progress                            |
// |           done         - the current cycle performs the final shift        |
// |           result       - work value after this cycle's shift               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module serial_shifter
  import mips_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic               dir,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [XLEN-1:0]    data_in,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d;
  logic               active_q, active_d;
  logic [XLEN-1:0]    shifted;

  always_comb begin
    shifted  = dir_q ? {1'b0, work_q[XLEN-1:1]} : {work_q[XLEN-2:0], 1'b0};
    work_d   = work_q;
    count_d  = count_q;
    dir_d    = dir_q;
    active_d = active_q;
    if (clear) begin
      active_d = 1'b0;
      count_d  = '0;
    end else if (load) begin
      work_d   = data_in;
      count_d  = shamt;
      dir_d    = dir;
      active_d = 1'b1;
    end else if (active_q) begin
      work_d  = shifted;
      count_d = count_q - SHAMT_W'(1);
      // Last shift (count 1) ends the run; a zero count can only arise from a
      // misuse of load and is treated as immediately finished.
      if (count_q <= SHAMT_W'(1)) begin
        active_d = 1'b0;
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q   <= '0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      work_q   <= work_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      active_q <= active_d;
    end
  end

  assign busy   = active_q;
  // Completion is flagged in the cycle that performs the last shift so the
  // consumer can register the final value on the same edge.
  assign done   = active_q & (count_q == SHAMT_W'(1));
  assign result = shifted;

endmodule : serial_shifter
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_exec_stage                                                   |
// | Purpose : Execute stage after ALU control. ADD/SUB/pass finish in one      |
// |           cycle; SLL/SRL run on a serial shifter (1 bit per cycle).        |
// |           Registered result and zero flag with valid/ready on both sides. |
// | Ports   : clk, reset          - clock, synchronous active-high reset       |
// |           flush               - drop in-flight op (below reset)            |
// |           in_valid/in_ready   - upstream handshake                         |
// |           in_aluop            - operation code (unknown codes = NONE)      |
// |           in_a, in_b          - operands                                   |
// |           in_shamt            - shift amount for SLL/SRL                   |
// |           out_valid/out_ready - downstream handshake                       |
// |           out_result,out_zero - registered result and (result == 0)       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alu_exec_stage
  import mips_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  aluop_t             in_aluop,
  input  logic [XLEN-1:0]    in_a,
  input  logic [XLEN-1:0]    in_b,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic               out_zero
);

  ex_state_t       state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  logic            accept;
  logic            needs_shift;
  logic            shift_load;
  logic            shift_dir;
  logic [XLEN-1:0] fast_result;
  logic            sh_busy;
  logic            sh_done;
  logic [XLEN-1:0] sh_result;

  // A held result that is being consumed frees the stage in the same cycle,
  // which is what gives back-to-back issue without a bubble.
  assign in_ready    = (state_q == EX_IDLE) | ((state_q == EX_DONE) & out_ready);
  assign accept      = in_valid & in_ready;
  assign needs_shift = is_shift_op(in_aluop) & (in_shamt != '0);
  // A flushed accept must not start the shifter either.
  assign shift_load  = accept & needs_shift & ~flush;
  assign shift_dir   = (in_aluop == ALU_SRL);

  // Single-cycle datapath; a zero-distance shift is a pass of operand b.
  always_comb begin
    fast_result = '0;
    case (in_aluop)
      ALU_ADD:          fast_result = in_a + in_b;
      ALU_SUB:          fast_result = in_a - in_b;
      ALU_SLL, ALU_SRL: fast_result = in_b;
      default:          fast_result = '0;
    endcase
  end

  serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (shift_load),
    .dir     (shift_dir),
    .shamt   (in_shamt),
    .data_in (in_b),
    .busy    (sh_busy),
    .done    (sh_done),
    .result  (sh_result)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept) begin
      if (needs_shift) begin
        state_d = EX_SHIFT;
      end else begin
        state_d  = EX_DONE;
        result_d = fast_result;
        zero_d   = (fast_result == '0);
      end
    end else begin
      case (state_q)
        EX_SHIFT: begin
          // The zero flag is taken only from the final shifted value.
          if (sh_done) begin
            state_d  = EX_DONE;
            result_d = sh_result;
            zero_d   = (sh_result == '0);
          end else if (!sh_busy) begin
            state_d = EX_IDLE;
          end
        end
        EX_DONE: begin
          if (out_ready) begin
            state_d = EX_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
    // Flush discards everything, including an accept in this same cycle.
    if (flush) begin
      state_d  = EX_IDLE;
      result_d = result_q;
      zero_d   = zero_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EX_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign out_valid  = (state_q == EX_DONE);
  assign out_result = result_q;
  assign out_zero   = zero_q;

endmodule : alu_exec_stage
`default_nettype wire
